kiwi_tma_counter: RTL and testbench

- Synthesizable top-down microarchitecture analysis (TMA) counter block for the kiwi core.
- Classifies every decode slot each cycle as one of: retiring-path issue, backend bound, frontend bound, or flush recovery. Also counts retired instructions.
- Generalised over decode width, counter width and flush-recovery window length. Adds snapshot, clear and saturation.
- Sits beside the decoder/ROB in kiwi_subsys. Software or the bench reads it through a select/data port.

---
 rtl/kiwi_tma_counter.sv | 141 ++++++++++++++
 tb/tb_kiwi_tma_counter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kiwi_tma_counter.sv
// Top-down microarchitecture analysis counters for the kiwi core: per-slot decode
// classification, retire count, flush-recovery window, snapshot shadows and saturation.
module kiwi_tma_counter #(
  parameter int unsigned SLOT_NUM  = 2,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned FLUSH_WIN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                clear_i,
  input  logic                snap_i,
  input  logic [SLOT_NUM-1:0] dec_valid_i,
  input  logic                backend_stall_i,
  input  logic                flush_i,
  input  logic [SLOT_NUM-1:0] retire_valid_i,
  input  logic [2:0]          rd_sel_i,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic                overflow_o,
  output logic                win_active_o
);

  localparam int unsigned IncW      = $clog2(SLOT_NUM + 1);
  localparam int unsigned NumCnt    = 6;
  localparam int unsigned CntSlots  = 0;
  localparam int unsigned CntIssue  = 1;
  localparam int unsigned CntBack   = 2;
  localparam int unsigned CntFront  = 3;
  localparam int unsigned CntFlush  = 4;
  localparam int unsigned CntRetire = 5;
  localparam logic [3:0]  WinLoad   = 4'(FLUSH_WIN);

  logic [NumCnt-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NumCnt-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NumCnt-1:0][CNT_W-1:0] cnt_sat;
  logic [NumCnt-1:0][CNT_W:0]   sum;
  logic [NumCnt-1:0][IncW-1:0]  inc;
  logic [NumCnt-1:0]            sat_hit;
  logic                         ovf_q, ovf_d;
  logic [3:0]                   win_q, win_d;
  logic [SLOT_NUM-1:0]          dec_empty;
  logic [IncW-1:0]              empty_cnt;
  logic [CNT_W-1:0]             badspec;

  function automatic logic [IncW-1:0] popcnt(input logic [SLOT_NUM-1:0] v);
    logic [IncW-1:0] c;
    c = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      c = c + IncW'(v[i]);
    end
    return c;
  endfunction

  assign win_active_o = (win_q != 4'd0);
  assign overflow_o   = ovf_q;

  // Empty slots are charged to flush recovery using the window state before this edge.
  always_comb begin
    dec_empty      = ~dec_valid_i;
    empty_cnt      = popcnt(dec_empty);
    inc            = '0;
    inc[CntSlots]  = IncW'(SLOT_NUM);
    inc[CntIssue]  = backend_stall_i ? '0 : popcnt(dec_valid_i);
    inc[CntBack]   = backend_stall_i ? popcnt(dec_valid_i) : '0;
    inc[CntFront]  = win_active_o ? '0 : empty_cnt;
    inc[CntFlush]  = win_active_o ? empty_cnt : '0;
    inc[CntRetire] = popcnt(retire_valid_i);
  end

  always_comb begin
    sum     = '0;
    cnt_sat = '0;
    sat_hit = '0;
    for (int i = 0; i < NumCnt; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + (CNT_W + 1)'(inc[i]);
      if (sum[i][CNT_W]) begin
        cnt_sat[i] = '1;
        sat_hit[i] = 1'b1;
      end else begin
        cnt_sat[i] = sum[i][CNT_W-1:0];
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    win_d    = win_q;
    if (clear_i) begin
      cnt_d    = '0;
      shadow_d = '0;
      ovf_d    = 1'b0;
      win_d    = 4'd0;
    end else begin
      if (en_i) begin
        cnt_d = cnt_sat;
        ovf_d = ovf_q | (|sat_hit);
      end
      if (snap_i) begin
        shadow_d = cnt_q;
      end
      if (flush_i) begin
        win_d = WinLoad;
      end else if (win_q != 4'd0) begin
        win_d = win_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      win_q    <= 4'd0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    badspec = (shadow_q[CntIssue] > shadow_q[CntRetire]) ?
              (shadow_q[CntIssue] - shadow_q[CntRetire]) : '0;
    rd_data_o = '0;
    case (rd_sel_i)
      3'd0:    rd_data_o = shadow_q[CntSlots];
      3'd1:    rd_data_o = shadow_q[CntIssue];
      3'd2:    rd_data_o = shadow_q[CntBack];
      3'd3:    rd_data_o = shadow_q[CntFront];
      3'd4:    rd_data_o = shadow_q[CntFlush];
      3'd5:    rd_data_o = shadow_q[CntRetire];
      3'd6:    rd_data_o = badspec;
      default: rd_data_o = {{(CNT_W-1){1'b0}}, ovf_q};
    endcase
  end

endmodule

// File: tb/tb_kiwi_tma_counter.sv
// Self-checking bench for kiwi_tma_counter: phase table, hand-written window,
// saturation, priority and reset sequences, then random stimulus against a model.
module tb_kiwi_tma_counter;

  localparam int unsigned SlotNum  = 2;
  localparam int unsigned CntW     = 16;
  localparam int unsigned FlushWin = 4;
  localparam longint unsigned MaxV = (64'd1 << CntW) - 64'd1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en, clear, snap, stall, flush;
  logic [1:0]      dec, ret;
  logic [2:0]      rd_sel;
  logic [CntW-1:0] rd_data;
  logic            ovf, win;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: live counts, shadows, sticky overflow, window cycles remaining.
  longint unsigned m_cnt [6];
  longint unsigned m_sh  [6];
  bit              m_ovf;
  int              m_win;

  kiwi_tma_counter #(
    .SLOT_NUM (SlotNum),
    .CNT_W    (CntW),
    .FLUSH_WIN(FlushWin)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en),
    .clear_i        (clear),
    .snap_i         (snap),
    .dec_valid_i    (dec),
    .backend_stall_i(stall),
    .flush_i        (flush),
    .retire_valid_i (ret),
    .rd_sel_i       (rd_sel),
    .rd_data_o      (rd_data),
    .overflow_o     (ovf),
    .win_active_o   (win)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_cnt[i] = 0;
      m_sh[i]  = 0;
    end
    m_ovf = 0;
    m_win = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input bit s, input logic [1:0] d,
                            input bit st, input bit f, input logic [1:0] r);
    longint unsigned inc [6];
    bit act;
    if (c) begin
      model_reset();
      return;
    end
    act = (m_win != 0);
    if (s) for (int i = 0; i < 6; i++) m_sh[i] = m_cnt[i];
    if (e) begin
      for (int i = 0; i < 6; i++) inc[i] = 0;
      inc[0] = SlotNum;
      for (int k = 0; k < SlotNum; k++) begin
        if (d[k]) begin
          if (st) inc[2]++; else inc[1]++;
        end else begin
          if (act) inc[4]++; else inc[3]++;
        end
        if (r[k]) inc[5]++;
      end
      for (int i = 0; i < 6; i++) begin
        if (m_cnt[i] + inc[i] > MaxV) begin
          m_cnt[i] = MaxV;
          m_ovf    = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + inc[i];
        end
      end
    end
    if (f) m_win = FlushWin;
    else if (m_win > 0) m_win = m_win - 1;
  endtask

  function automatic longint unsigned model_read(input int sel);
    if (sel < 6) return m_sh[sel];
    if (sel == 6) return (m_sh[1] > m_sh[5]) ? m_sh[1] - m_sh[5] : 0;
    return {63'd0, m_ovf};
  endfunction

  task automatic step(input bit e, input bit c, input bit s, input logic [1:0] d,
                      input bit st, input bit f, input logic [1:0] r);
    en = e; clear = c; snap = s; dec = d; stall = st; flush = f; ret = r;
    @(posedge clk);
    model_step(e, c, s, d, st, f, r);
    #1;
  endtask

  task automatic read_check(input string name, input int sel, input logic [63:0] exp);
    rd_sel = sel[2:0];
    #1;
    check($sformatf("%s sel%0d", name, sel), {48'd0, rd_data}, exp);
  endtask

  // Phase: clear, ncyc counted cycles, frozen snapshot, then read all eight selects.
  typedef struct packed {
    logic [7:0]        ncyc;
    logic [1:0]        dec;
    logic              stall;
    logic [1:0]        ret;
    logic              flush0;
    logic [7:0][15:0]  exp;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [1:0] d, input bit st,
                              input logic [1:0] r, input bit f0, input int s, input int i,
                              input int b, input int fe, input int fr, input int rt,
                              input int bad);
    vec_t v;
    v.ncyc = 8'(n); v.dec = d; v.stall = st; v.ret = r; v.flush0 = f0;
    v.exp[0] = 16'(s);  v.exp[1] = 16'(i);  v.exp[2] = 16'(b);  v.exp[3] = 16'(fe);
    v.exp[4] = 16'(fr); v.exp[5] = 16'(rt); v.exp[6] = 16'(bad); v.exp[7] = 16'd0;
    return v;
  endfunction

  task automatic window_seq(input string name, input int gap, input logic [9:0] exp_pat,
                            input int exp_fr, input int exp_fe);
    logic [9:0] pat;
    step(0, 1, 0, 2'b00, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00, 0, 1, 2'b00);
    for (int k = 0; k < 10; k++) begin
      pat[k] = win;
      step(1, 0, 0, 2'b00, 0, (k + 1 == gap), 2'b00);
    end
    check({name, " win pattern"}, {54'd0, pat}, {54'd0, exp_pat});
    step(0, 0, 1, 2'b00, 0, 0, 2'b00);
    read_check({name, " flushrec"}, 4, 64'(exp_fr));
    read_check({name, " frontend"}, 3, 64'(exp_fe));
  endtask

  vec_t vecs [7];

  initial begin
    rst_n = 1'b0;
    en = 0; clear = 0; snap = 0; stall = 0; flush = 0; dec = '0; ret = '0; rd_sel = '0;
    model_reset();
    #12;
    for (int s = 0; s < 8; s++) read_check("reset", s, 64'd0);
    check("reset ovf", {63'd0, ovf}, 64'd0);
    check("reset win", {63'd0, win}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = mk(10, 2'b00, 0, 2'b00, 0, 20, 0, 0, 20, 0, 0, 0);
    vecs[1] = mk(5,  2'b11, 1, 2'b00, 0, 10, 0, 10, 0, 0, 0, 0);
    vecs[2] = mk(5,  2'b01, 0, 2'b01, 0, 10, 5, 0, 5, 0, 5, 0);
    vecs[3] = mk(3,  2'b11, 0, 2'b00, 0, 6, 6, 0, 0, 0, 0, 6);
    vecs[4] = mk(4,  2'b00, 0, 2'b11, 0, 8, 0, 0, 8, 0, 8, 0);
    vecs[5] = mk(10, 2'b00, 0, 2'b00, 1, 20, 0, 0, 12, 8, 0, 0);
    vecs[6] = mk(6,  2'b10, 0, 2'b10, 1, 12, 6, 0, 2, 4, 6, 0);
    for (int v = 0; v < 7; v++) begin
      step(0, 1, 0, 2'b00, 0, 0, 2'b00);
      for (int k = 0; k < int'(vecs[v].ncyc); k++)
        step(1, 0, 0, vecs[v].dec, vecs[v].stall, vecs[v].flush0 && k == 0, vecs[v].ret);
      step(0, 0, 1, 2'b00, 0, 0, 2'b00);
      for (int s = 0; s < 8; s++)
        read_check($sformatf("vec%0d", v), s, {48'd0, vecs[v].exp[s]});
    end

    // Mixed classification then additional issue-only cycles.
    step(0, 1, 0, 2'b00, 0, 0, 2'b00);
    repeat (5) step(1, 0, 0, 2'b11, 1, 0, 2'b00);
    repeat (5) step(1, 0, 0, 2'b01, 0, 0, 2'b01);
    step(0, 0, 1, 2'b00, 0, 0, 2'b00);
    read_check("mixed backend", 2, 64'd10);
    read_check("mixed issue", 1, 64'd5);
    read_check("mixed front", 3, 64'd5);
    read_check("mixed retire", 5, 64'd5);
    read_check("mixed badspec", 6, 64'd0);
    repeat (3) step(1, 0, 0, 2'b01, 0, 0, 2'b00);
    step(0, 0, 1, 2'b00, 0, 0, 2'b00);
    read_check("mixed badspec2", 6, 64'd3);

    window_seq("win single", 99, 10'b0000001111, 8, 14);
    window_seq("win gap2", 2, 10'b0000111111, 12, 10);
    window_seq("win gap3", 3, 10'b0001111111, 14, 8);

    // Saturation: SLOTS and FRONTEND reach all-ones on the same cycle.
    step(0, 1, 0, 2'b00, 0, 0, 2'b00);
    repeat (32767) step(1, 0, 0, 2'b00, 0, 0, 2'b00);
    check("sat pre ovf", {63'd0, ovf}, 64'd0);
    step(1, 0, 1, 2'b00, 0, 0, 2'b00);
    read_check("sat pre slots", 0, 64'hFFFE);
    check("sat ovf", {63'd0, ovf}, 64'd1);
    step(1, 0, 0, 2'b00, 0, 0, 2'b00);
    step(0, 0, 1, 2'b00, 0, 0, 2'b00);
    read_check("sat slots", 0, 64'hFFFF);
    read_check("sat front", 3, 64'hFFFF);
    read_check("sat flushrec", 4, 64'd0);
    read_check("sat ovf read", 7, 64'd1);
    step(0, 1, 0, 2'b00, 0, 0, 2'b00);
    check("clear ovf", {63'd0, ovf}, 64'd0);
    read_check("clear slots", 0, 64'd0);
    read_check("clear ovf read", 7, 64'd0);

    // clear wins over snap and flush in the same cycle.
    repeat (4) step(1, 0, 0, 2'b11, 0, 0, 2'b11);
    step(1, 0, 1, 2'b01, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00, 0, 1, 2'b00);
    check("prio win before", {63'd0, win}, 64'd1);
    step(1, 1, 1, 2'b11, 0, 1, 2'b11);
    check("prio win", {63'd0, win}, 64'd0);
    for (int s = 0; s < 8; s++) read_check("prio", s, 64'd0);

    // Asynchronous reset mid-count with a live window and nonzero shadows.
    repeat (5) step(1, 0, 0, 2'b01, 0, 0, 2'b01);
    step(1, 0, 1, 2'b01, 0, 1, 2'b01);
    rd_sel = 3'd0;
    #1;
    check("pre-reset slots", {48'd0, rd_data}, model_read(0));
    check("pre-reset win", {63'd0, win}, 64'd1);
    en = 1; dec = 2'b11; snap = 0; flush = 0; clear = 0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst data", {48'd0, rd_data}, 64'd0);
    check("async rst win", {63'd0, win}, 64'd0);
    check("async rst ovf", {63'd0, ovf}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model.
    for (int t = 0; t < 800; t++) begin
      int sel;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           2'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, 2'($urandom));
      sel = $urandom_range(0, 7);
      read_check("rand", sel, model_read(sel));
      check("rand win", {63'd0, win}, {63'd0, m_win != 0});
      check("rand ovf", {63'd0, ovf}, {63'd0, m_ovf});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
